// File: rtl/vending_pkg.sv
// Shared definitions for the vending coin front end.
//   - coin codes driven on the 2-bit coin buses
//   - price constants used by the shadow credit checker
//   - scheduler FSM state type
//   - coin_value(): code -> monetary value (0, 5 or 10)
package vending_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;
   localparam logic [1:0] COIN_INV  = 2'b11;

   localparam logic [4:0] PRICE      = 5'd20;
   // Credit that forces both a vend and a 5-unit change return.
   localparam logic [4:0] PRICE_CHG5 = 5'd25;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP
   } sched_state_t;

   function automatic logic [4:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_5:  return 5'd5;
         COIN_10: return 5'd10;
         default: return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_slot_fifo.sv
// Per-slot coin buffer: small FIFO of 2-bit coin codes.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset (flushes the buffer)
//   push  - write din at the tail (only asserted while ready=1)
//   din   - coin code to store
//   pop   - drop the head (only asserted while empty=0)
//   dout  - current head entry, valid whenever empty=0
//   empty - no stored entries
//   ready - registered occupancy below DEPTH; a pop in the same cycle
//           does not raise it
module coin_slot_fifo
   import vending_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [1:0] din,
   input  logic       pop,
   output logic [1:0] dout,
   output logic       empty,
   output logic       ready
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   logic [1:0]       mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [OCC_W-1:0] occ_reg;

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ_reg <= occ_reg + OCC_W'(1);
            2'b01:   occ_reg <= occ_reg - OCC_W'(1);
            default: occ_reg <= occ_reg;
         endcase
      end
   end

   // Head is read directly so a coin buffered at one edge can be issued
   // at the very next edge.
   assign dout  = mem_reg[rd_ptr_reg];
   assign empty = (occ_reg == '0);
   assign ready = (occ_reg < FULL_OCC);

endmodule

// File: rtl/vending_coin_scheduler.sv
// Front-end scheduler for the vending_mealy core.
// Buffers coins from two valid/ready slots, arbitrates round-robin, and
// issues each coin to the core as a one-cycle pulse followed by an idle
// cycle. A shadow credit register predicts the core's Mealy outputs; any
// disagreement sets a sticky mismatch flag.
// Ports:
//   clk, rst                  - clock; synchronous active-low reset
//   s0_coin/s0_valid/s0_ready - slot 0 handshake
//   s1_coin/s1_valid/s1_ready - slot 1 handshake
//   hold                      - blocks new issues (accepts continue)
//   core_coin                 - registered coin drive to the core
//   core_dispense, core_chg5  - core outputs, checked during ISSUE
//   credit                    - shadow credit (0/5/10/15)
//   vend_count, chg_count     - observed dispense / change events
//   reject                    - one-cycle pulse when an invalid coin is dropped
//   mismatch                  - sticky core/shadow disagreement
module vending_coin_scheduler
   import vending_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       s0_coin,
   input  logic             s0_valid,
   output logic             s0_ready,
   input  logic [1:0]       s1_coin,
   input  logic             s1_valid,
   output logic             s1_ready,
   input  logic             hold,
   output logic [1:0]       core_coin,
   input  logic             core_dispense,
   input  logic             core_chg5,
   output logic [4:0]       credit,
   output logic [CNT_W-1:0] vend_count,
   output logic [CNT_W-1:0] chg_count,
   output logic             reject,
   output logic             mismatch
);

   logic [1:0] slot_coin  [2];
   logic [1:0] slot_dout  [2];
   logic [1:0] slot_valid;
   logic [1:0] slot_ready;
   logic [1:0] slot_empty;
   logic [1:0] slot_push;
   logic [1:0] slot_inv;
   logic [1:0] slot_pop;

   sched_state_t     state_reg;
   logic [1:0]       core_coin_reg;
   logic [4:0]       credit_reg;
   logic [CNT_W-1:0] vend_count_reg;
   logic [CNT_W-1:0] chg_count_reg;
   logic             reject_reg;
   logic             mismatch_reg;
   logic             last_grant_reg;

   logic       grant;
   logic [4:0] sum;
   logic       exp_d;
   logic       exp_c;

   assign slot_coin[0]  = s0_coin;
   assign slot_coin[1]  = s1_coin;
   assign slot_valid[0] = s0_valid;
   assign slot_valid[1] = s1_valid;
   assign s0_ready      = slot_ready[0];
   assign s1_ready      = slot_ready[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         // Only real coins are stored; 00 and 11 are consumed on transfer.
         assign slot_push[gi] = slot_valid[gi] & slot_ready[gi] &
                                ((slot_coin[gi] == COIN_5) || (slot_coin[gi] == COIN_10));
         assign slot_inv[gi]  = slot_valid[gi] & slot_ready[gi] &
                                (slot_coin[gi] == COIN_INV);

         coin_slot_fifo #(
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (slot_push[gi]),
            .din   (slot_coin[gi]),
            .pop   (slot_pop[gi]),
            .dout  (slot_dout[gi]),
            .empty (slot_empty[gi]),
            .ready (slot_ready[gi])
         );
      end
   endgenerate

   // Round-robin grant: with both slots pending, the slot not served last
   // wins; otherwise the only non-empty slot is taken.
   always_comb begin
      grant    = 1'b0;
      slot_pop = 2'b00;
      if ((state_reg == IDLE) && !hold && !(slot_empty[0] && slot_empty[1])) begin
         if (!slot_empty[0] && !slot_empty[1]) begin
            grant = ~last_grant_reg;
         end else begin
            grant = slot_empty[0];
         end
         slot_pop[grant] = 1'b1;
      end
   end

   // Expected core response to the coin currently on core_coin.
   assign sum   = credit_reg + coin_value(core_coin_reg);
   assign exp_d = (sum >= PRICE);
   assign exp_c = (sum == PRICE_CHG5);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= IDLE;
         core_coin_reg  <= COIN_NONE;
         credit_reg     <= '0;
         vend_count_reg <= '0;
         chg_count_reg  <= '0;
         reject_reg     <= 1'b0;
         mismatch_reg   <= 1'b0;
         // Pretend slot 1 was served last so slot 0 wins the first tie.
         last_grant_reg <= 1'b1;
      end else begin
         // Both slots dropping 11 together still yields a single pulse.
         reject_reg <= |slot_inv;
         case (state_reg)
            IDLE: begin
               if (core_dispense || core_chg5) begin
                  mismatch_reg <= 1'b1;
               end
               if (|slot_pop) begin
                  core_coin_reg  <= slot_dout[grant];
                  last_grant_reg <= grant;
                  state_reg      <= ISSUE;
               end
            end
            ISSUE: begin
               credit_reg     <= exp_d ? 5'd0 : sum;
               vend_count_reg <= vend_count_reg + CNT_W'(core_dispense);
               chg_count_reg  <= chg_count_reg + CNT_W'(core_chg5);
               if ((core_dispense != exp_d) || (core_chg5 != exp_c)) begin
                  mismatch_reg <= 1'b1;
               end
               core_coin_reg <= COIN_NONE;
               state_reg     <= GAP;
            end
            GAP: begin
               if (core_dispense || core_chg5) begin
                  mismatch_reg <= 1'b1;
               end
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign core_coin  = core_coin_reg;
   assign credit     = credit_reg;
   assign vend_count = vend_count_reg;
   assign chg_count  = chg_count_reg;
   assign reject     = reject_reg;
   assign mismatch   = mismatch_reg;

endmodule

// File: tb/tb_vending_coin_scheduler.sv
// Bench for vending_coin_scheduler: directed steps followed by random
// traffic, checked every cycle against a queue-based reference model. A
// behavioural vending core reacts to the DUT's core_coin.
module tb_vending_coin_scheduler;

   localparam int DEPTH = 2;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst;
   logic [1:0]       s0_coin;
   logic             s0_valid;
   logic             s0_ready;
   logic [1:0]       s1_coin;
   logic             s1_valid;
   logic             s1_ready;
   logic             hold;
   logic [1:0]       core_coin;
   logic             core_dispense;
   logic             core_chg5;
   logic [4:0]       credit;
   logic [CNT_W-1:0] vend_count;
   logic [CNT_W-1:0] chg_count;
   logic             reject;
   logic             mismatch;

   vending_coin_scheduler #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s0_coin       (s0_coin),
      .s0_valid      (s0_valid),
      .s0_ready      (s0_ready),
      .s1_coin       (s1_coin),
      .s1_valid      (s1_valid),
      .s1_ready      (s1_ready),
      .hold          (hold),
      .core_coin     (core_coin),
      .core_dispense (core_dispense),
      .core_chg5     (core_chg5),
      .credit        (credit),
      .vend_count    (vend_count),
      .chg_count     (chg_count),
      .reject        (reject),
      .mismatch      (mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model state.
   logic [1:0]       mq0[$];
   logic [1:0]       mq1[$];
   logic [1:0]       m_coin;
   int               m_credit;
   logic [CNT_W-1:0] m_vend;
   logic [CNT_W-1:0] m_chg;
   bit               m_rej;
   bit               m_mis;
   int               busy;      // cycles left for the coin in flight (2 = on the bus)
   int               last;      // slot served most recently
   // Behavioural core and bench bookkeeping.
   int               core_cr;
   bit               force_gap;
   logic [1:0]       issued[$];

   function automatic int val(input logic [1:0] c);
      return (c == 2'd1) ? 5 : ((c == 2'd2) ? 10 : 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance the model across one rising edge using the inputs about to be sampled.
   task automatic model_step();
      bit acc0, acc1;
      int s, g;
      if (!rst) begin
         core_cr = 0;
         mq0.delete(); mq1.delete();
         m_coin = 2'd0; m_credit = 0; m_vend = '0; m_chg = '0;
         m_rej = 0; m_mis = 0; busy = 0; last = 1;
         return;
      end
      if (core_coin != 2'd0) begin
         s = core_cr + val(core_coin);
         core_cr = (s >= 20) ? 0 : s;
      end
      acc0  = s0_valid && (mq0.size() < DEPTH);
      acc1  = s1_valid && (mq1.size() < DEPTH);
      m_rej = (acc0 && s0_coin == 2'd3) || (acc1 && s1_coin == 2'd3);
      if (busy == 2) begin
         s = m_credit + val(m_coin);
         if (core_dispense != (s >= 20) || core_chg5 != (s == 25)) m_mis = 1;
         m_credit = (s >= 20) ? 0 : s;
         m_vend   = m_vend + CNT_W'(core_dispense);
         m_chg    = m_chg + CNT_W'(core_chg5);
         m_coin   = 2'd0;
         busy     = 1;
      end else begin
         if (core_dispense || core_chg5) m_mis = 1;
         if (busy == 1) begin
            busy = 0;
         end else if (!hold && (mq0.size() != 0 || mq1.size() != 0)) begin
            if (mq0.size() != 0 && mq1.size() != 0) g = (last == 0) ? 1 : 0;
            else g = (mq0.size() != 0) ? 0 : 1;
            m_coin = (g == 0) ? mq0.pop_front() : mq1.pop_front();
            last   = g;
            busy   = 2;
         end
      end
      if (acc0 && (s0_coin == 2'd1 || s0_coin == 2'd2)) mq0.push_back(s0_coin);
      if (acc1 && (s1_coin == 2'd1 || s1_coin == 2'd2)) mq1.push_back(s1_coin);
   endtask

   // Behavioural Mealy core: reacts to the coin currently driven.
   task automatic core_drive();
      int v;
      v = val(core_coin);
      core_dispense = (core_coin != 2'd0) && (core_cr + v >= 20);
      core_chg5     = (core_coin != 2'd0) && (core_cr + v == 25);
      if (force_gap && busy == 1) core_dispense = 1'b1;
   endtask

   task automatic check_all();
      chk("core_coin",  32'(core_coin),  32'(m_coin));
      chk("credit",     32'(credit),     32'(m_credit));
      chk("vend_count", 32'(vend_count), 32'(m_vend));
      chk("chg_count",  32'(chg_count),  32'(m_chg));
      chk("reject",     32'(reject),     32'(m_rej));
      chk("mismatch",   32'(mismatch),   32'(m_mis));
      chk("s0_ready",   32'(s0_ready),   32'(mq0.size() < DEPTH));
      chk("s1_ready",   32'(s1_ready),   32'(mq1.size() < DEPTH));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      core_drive();
      if (core_coin != 2'd0) begin
         issued.push_back(core_coin);
         $display("cycle %0d: issue coin %0b disp=%0b chg5=%0b", cyc, core_coin, core_dispense, core_chg5);
      end
      check_all();
   endtask

   task automatic drain(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // Offer one coin on a slot and hold it until the model says it was taken.
   task automatic send(input int slot, input logic [1:0] code);
      bit done;
      int n;
      done = 0;
      n    = 0;
      if (slot == 0) begin s0_valid = 1'b1; s0_coin = code; end
      else           begin s1_valid = 1'b1; s1_coin = code; end
      while (!done && n < 40) begin
         done = (slot == 0) ? (mq0.size() < DEPTH) : (mq1.size() < DEPTH);
         tick();
         n++;
      end
      chk("send_accepted", 32'(done), 32'd1);
      s0_valid = 1'b0;
      s1_valid = 1'b0;
   endtask

   logic [1:0] exp_ord [3];

   initial begin
      rst = 1'b0; s0_coin = 2'd0; s0_valid = 1'b0; s1_coin = 2'd0; s1_valid = 1'b0;
      hold = 1'b0; core_dispense = 1'b0; core_chg5 = 1'b0; force_gap = 0;

      // Reset held two cycles.
      tick(); tick();
      chk("rst_core_coin", 32'(core_coin), 32'd0);
      chk("rst_s0_ready",  32'(s0_ready),  32'd1);
      chk("rst_vend",      32'(vend_count), 32'd0);
      rst = 1'b1;

      // Two 10s on slot 0: second completes a vend.
      issued.delete();
      send(0, 2'd2);
      send(0, 2'd2);
      drain(6);
      chk("t1_issues", 32'(issued.size()), 32'd2);
      chk("t1_vend",   32'(vend_count),    32'd1);
      chk("t1_chg",    32'(chg_count),     32'd0);
      chk("t1_credit", 32'(credit),        32'd0);

      // Same-cycle accepts on both slots, then slot 0 again.
      do_reset();
      issued.delete();
      s0_valid = 1'b1; s0_coin = 2'd1; s1_valid = 1'b1; s1_coin = 2'd2;
      tick();
      s1_valid = 1'b0;
      send(0, 2'd2);
      drain(10);
      exp_ord[0] = 2'd1; exp_ord[1] = 2'd2; exp_ord[2] = 2'd2;
      chk("t2_issues", 32'(issued.size()), 32'd3);
      for (int i = 0; i < 3 && i < issued.size(); i++) chk("t2_order", 32'(issued[i]), 32'(exp_ord[i]));
      chk("t2_vend", 32'(vend_count), 32'd1);
      chk("t2_chg",  32'(chg_count),  32'd1);

      // Hold with a full slot-0 buffer.
      issued.delete();
      hold = 1'b1;
      s0_valid = 1'b1; s0_coin = 2'd1; tick();
      s0_coin = 2'd2; tick();
      s0_coin = 2'd1; tick(); tick(); tick();
      chk("hold_s0_ready",  32'(s0_ready),  32'd0);
      chk("hold_core_coin", 32'(core_coin), 32'd0);
      hold = 1'b0;
      tick(); tick();
      s0_valid = 1'b0;
      drain(10);
      exp_ord[0] = 2'd1; exp_ord[1] = 2'd2; exp_ord[2] = 2'd1;
      chk("hold_issues", 32'(issued.size()), 32'd3);
      for (int i = 0; i < 3 && i < issued.size(); i++) chk("hold_order", 32'(issued[i]), 32'(exp_ord[i]));

      // Invalid coins: single slot, then both slots together.
      s1_valid = 1'b1; s1_coin = 2'd3; tick();
      s1_valid = 1'b0;
      chk("rej_pulse", 32'(reject), 32'd1);
      tick();
      chk("rej_clear", 32'(reject), 32'd0);
      chk("rej_coin",  32'(core_coin), 32'd0);
      s0_valid = 1'b1; s0_coin = 2'd3; s1_valid = 1'b1; s1_coin = 2'd3; tick();
      s0_valid = 1'b0; s1_valid = 1'b0;
      chk("rej_both", 32'(reject), 32'd1);
      tick();
      chk("rej_both_clear", 32'(reject), 32'd0);

      // Spurious dispense during GAP sets the sticky flag.
      force_gap = 1;
      send(0, 2'd1);
      drain(6);
      force_gap = 0;
      core_drive();
      drain(4);
      chk("mis_sticky", 32'(mismatch), 32'd1);

      // Reset while a coin is on the bus, with another still buffered.
      send(0, 2'd2);
      send(0, 2'd1);
      for (int i = 0; i < 10 && busy != 2; i++) tick();
      chk("pre_rst_issue", 32'(core_coin != 2'd0), 32'd1);
      do_reset();
      chk("mid_rst_coin",   32'(core_coin), 32'd0);
      chk("mid_rst_credit", 32'(credit),    32'd0);
      chk("mid_rst_mis",    32'(mismatch),  32'd0);
      issued.delete();
      drain(5);
      chk("flushed", 32'(issued.size()), 32'd0);

      // Random traffic with occasional hold.
      for (int i = 0; i < 400; i++) begin
         s0_valid = 1'($urandom_range(0, 1));
         s0_coin  = 2'($urandom_range(0, 3));
         s1_valid = 1'($urandom_range(0, 1));
         s1_coin  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) hold = ~hold;
         tick();
      end
      s0_valid = 1'b0; s1_valid = 1'b0; hold = 1'b0;
      drain(20);
      chk("rand_no_mis", 32'(mismatch), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
